// File: rtl/core_bus_pkg.sv
// core_bus_pkg: shared state encoding, default parameters and width helper
// for the core-to-Wishbone bridge.
package core_bus_pkg;
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
   localparam int DEF_NUM_PORTS      = 2;
   localparam int DEF_ADDR_WIDTH     = 32;
   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_TIMEOUT_CYCLES = 255;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr.
module rr_arbiter import core_bus_pkg::*; #(
   parameter int NUM_PORTS = DEF_NUM_PORTS
)(
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [idx_w(NUM_PORTS)-1:0] ptr,
   output logic [NUM_PORTS-1:0]        gnt
);
   int  k;
   logic found;
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         k = (int'(ptr) + i) % NUM_PORTS;
         if (!found && req[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/core_bus_bridge.sv
// core_bus_bridge: arbitrates core request ports onto one Wishbone classic
// master, one outstanding cycle at a time, with optional bus timeout.
module core_bus_bridge import core_bus_pkg::*; #(
   parameter int NUM_PORTS      = DEF_NUM_PORTS,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS-1:0]              req_valid_i,
   input  logic [NUM_PORTS-1:0]              req_we_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb_i,
   output logic [NUM_PORTS-1:0]              req_ready_o,
   output logic [NUM_PORTS-1:0]              rsp_valid_o,
   output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
   output logic                              rsp_err_o,
   output logic                              wb_cyc_o,
   output logic                              wb_stb_o,
   output logic                              wb_we_o,
   output logic [ADDR_WIDTH-1:0]             wb_adr_o,
   output logic [DATA_WIDTH-1:0]             wb_dat_o,
   output logic [DATA_WIDTH/8-1:0]           wb_sel_o,
   input  logic [DATA_WIDTH-1:0]             wb_dat_i,
   input  logic                              wb_ack_i,
   input  logic                              wb_err_i
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int PW = idx_w(NUM_PORTS);
   localparam int CW = idx_w(TIMEOUT_CYCLES + 1);

   state_t               state, state_nxt;
   logic [NUM_PORTS-1:0] gnt;
   logic [PW-1:0]        ptr, gidx, gidx_q;
   logic [CW-1:0]        cnt;
   logic                 we_q, tmo, done;

   rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (.req(req_valid_i), .ptr(ptr), .gnt(gnt));

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (gnt[i]) gidx = PW'(i);
   end

   // the timeout fires in the cycle that would be the TIMEOUT_CYCLES-th of BUS
   assign tmo  = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign done = wb_ack_i || wb_err_i || tmo;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt   = (state == IDLE) ? ((|req_valid_i) ? BUS : IDLE) :
                    (state == BUS)  ? (done ? RESP : BUS) : IDLE;
      req_ready_o = (state == IDLE) ? gnt : '0;
      rsp_valid_o = (state == RESP) ? (NUM_PORTS'(1) << gidx_q) : '0;
      wb_cyc_o    = (state == BUS);
      wb_stb_o    = (state == BUS);
      wb_we_o     = (state == BUS) && we_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q        <= 1'b0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         wb_sel_o    <= '0;
         gidx_q      <= '0;
         ptr         <= '0;
         cnt         <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         if (state == IDLE && |req_valid_i) begin
            we_q     <= req_we_i[gidx];
            wb_adr_o <= req_addr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
            wb_dat_o <= req_wdata_i[gidx*DATA_WIDTH +: DATA_WIDTH];
            wb_sel_o <= req_wstrb_i[gidx*SW +: SW];
            gidx_q   <= gidx;
         end
         if (state == BUS) begin
            cnt <= cnt + 1'b1;
            // error beats ack; a bare timeout (no ack) also reports error
            if (done) begin
               rsp_rdata_o <= (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : '0;
               rsp_err_o   <= wb_err_i || !wb_ack_i;
            end
         end
         if (state == RESP) begin
            ptr <= (gidx_q == PW'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;
            cnt <= '0;
         end
      end
   end
endmodule

// File: doc/core_bus_bridge.md
CORE_BUS_BRIDGE -- requirements
Module: core_bus_bridge

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of core-side request ports (port 0 = instruction, port 1 = data); legal range 1..8.
REQ-002 Parameter ADDR_WIDTH, default 32, address width on both sides.
REQ-003 Parameter DATA_WIDTH, default 32, data width; must be a multiple of 8.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, maximum bus cycles before forced termination; 0 disables the timeout.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  NUM_PORTS  per-port request pending.
REQ-008 req_we_i  input  NUM_PORTS  per-port write enable (1 = write).
REQ-009 req_addr_i  input  NUM_PORTS*ADDR_WIDTH  packed per-port address.
REQ-010 req_wdata_i  input  NUM_PORTS*DATA_WIDTH  packed per-port write data.
REQ-011 req_wstrb_i  input  NUM_PORTS*DATA_WIDTH/8  packed per-port byte strobes.
REQ-012 req_ready_o  output  NUM_PORTS  one-cycle accept pulse to the granted port.
REQ-013 rsp_valid_o  output  NUM_PORTS  one-cycle response pulse to the owning port.
REQ-014 rsp_rdata_o  output  DATA_WIDTH  shared registered read data.
REQ-015 rsp_err_o  output  1  response error flag, qualified by any rsp_valid_o bit.
REQ-016 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone classic control.
REQ-017 wb_adr_o  output  ADDR_WIDTH; wb_dat_o  output  DATA_WIDTH; wb_sel_o  output  DATA_WIDTH/8.
REQ-018 wb_dat_i  input  DATA_WIDTH; wb_ack_i  input  1; wb_err_i  input  1.

Function
REQ-019 FSM states: IDLE, BUS, RESP.
REQ-020 IDLE: if any req_valid_i bit is set, the bridge grants one port round-robin starting at the priority pointer, latches we/addr/wdata/wstrb, pulses req_ready_o for that port, and enters BUS; otherwise it stays in IDLE.
REQ-021 BUS: wb_cyc_o = wb_stb_o = 1, driven from latched fields only; the timeout counter increments every BUS cycle.
REQ-022 BUS exit on wb_ack_i or wb_err_i: capture wb_dat_i (reads) or 0 (writes) into rsp_rdata_o, set rsp_err_o = wb_err_i, enter RESP; cyc/stb deassert in the following cycle.
REQ-023 Simultaneous wb_ack_i and wb_err_i: error wins (rsp_err_o = 1, rsp_rdata_o = 0).
REQ-024 Timeout: when TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with no ack/err, the bridge enters RESP with rsp_err_o = 1 and rsp_rdata_o = 0; an ack in the terminal cycle wins over the timeout.
REQ-025 RESP: rsp_valid_o pulses for exactly one cycle on the granted port, the priority pointer becomes (granted+1) mod NUM_PORTS, the counter clears, and the FSM returns to IDLE.
REQ-026 Latency: accept in cycle N, cyc asserted N+1, ack in cycle M, rsp_valid_o in M+1, next accept earliest M+2.
REQ-027 wb_ack_i/wb_err_i outside BUS are ignored; req_valid_i dropping before its ready pulse is legal and has no effect.
REQ-028 Outside BUS, wb_cyc_o/wb_stb_o/wb_we_o = 0; wb_adr_o/wb_dat_o/wb_sel_o hold their last latched values.
REQ-029 NUM_PORTS = 1 degenerates to a fixed grant; behaviour is otherwise identical.

Reset
REQ-030 On rst_n low, asynchronously: FSM = IDLE, all outputs 0, latched fields 0, pointer 0, counter 0.
REQ-031 Reset asserted mid-BUS drops wb_cyc_o immediately, and no response is ever issued for the aborted request.

Structure
REQ-032 Package core_bus_pkg holds the state enum and the default parameter constants.
REQ-033 Sub-module rr_arbiter (NUM_PORTS requests, pointer in, one-hot grant out, combinational) performs grant selection.

Verification
REQ-034 Single read, port 0, addr 0x100, slave ack with 0xDEADBEEF after 2 wait cycles -> rsp_valid_o[0] 1 cycle later with rsp_rdata_o = 0xDEADBEEF and rsp_err_o = 0.
REQ-035 Both ports valid continuously for 4 transactions, zero-wait slave -> grants 0,1,0,1; exactly one req_ready_o pulse per transaction.
REQ-036 Write, port 1, addr 0x2004, data 0x12345678, strobe 0b0011 -> wb_we_o = 1, wb_sel_o = 0x3, wb_dat_o = 0x12345678; response rdata = 0.
REQ-037 TIMEOUT_CYCLES = 4, slave never acks -> cyc high exactly 4 cycles, then rsp_valid_o with rsp_err_o = 1.
REQ-038 wb_ack_i and wb_err_i asserted together -> rsp_err_o = 1; late ack pulse in IDLE -> no rsp_valid_o.
REQ-039 rst_n low during the 2nd BUS cycle -> wb_cyc_o = 0 without a clock edge; after release, no rsp_valid_o and the pointer restarts at port 0.
